prewitt_scan_ctrl: RTL

//  Raster-scan sequencer for the Prewitt edge pipeline. On start, walks a ROWS x COLS
//  8-bit image held in a sync-read pixel RAM, fetches each interior 3x3 window, hands it
//  to the external Prewitt kernel (valid/ready), and writes the returned magnitude to the

---
 rtl/prewitt_pkg.sv | 37 +++
 rtl/prewitt_win_addr_gen.sv | 41 ++++
 rtl/prewitt_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/prewitt_pkg.sv
// rtl/prewitt_pkg.sv - shared types, widths and window offsets for the Prewitt scan sequencer
package prewitt_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_W    = 72;
  localparam int DEF_ROWS = 242;
  localparam int DEF_COLS = 247;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_BORDER,
    ST_FETCH,
    ST_CAPT,
    ST_HAND,
    ST_WAITR,
    ST_WRITE,
    ST_FIN
  } state_e;

  // Offset of window tap k from the top-left pixel; cols is a constant, so this folds to a mux.
  function automatic int off(input logic [3:0] k, input int cols);
    case (k)
      4'd0:    off = 0;
      4'd1:    off = 1;
      4'd2:    off = 2;
      4'd3:    off = cols;
      4'd4:    off = cols + 1;
      4'd5:    off = cols + 2;
      4'd6:    off = cols + cols;
      4'd7:    off = cols + cols + 1;
      4'd8:    off = cols + cols + 2;
      default: off = 0;
    endcase
  endfunction

endpackage

// File: rtl/prewitt_win_addr_gen.sv
// rtl/prewitt_win_addr_gen.sv - walks the nine taps of a 3x3 window from its top-left base address
module prewitt_win_addr_gen
  import prewitt_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        k,
  output logic              last_k
);

  logic [3:0] k_q, k_d;

  assign last_k = (k_q == 4'd8);
  assign k      = k_q;
  assign addr   = base + ADDR_W'(off(k_q, COLS));

  always_comb begin
    k_d = k_q;
    if (clr) begin
      k_d = '0;
    end else if (step) begin
      k_d = last_k ? 4'd0 : k_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/prewitt_scan_ctrl.sv
// rtl/prewitt_scan_ctrl.sv - raster sequencer: fetches 3x3 windows, hands them to the kernel, writes results
module prewitt_scan_ctrl
  import prewitt_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win,
  input  logic              res_valid,
  input  logic [PIX_W-1:0]  res_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int R_W = $clog2(ROWS);
  localparam int C_W = $clog2(COLS);
  localparam logic [R_W-1:0]    R_LAST   = R_W'(ROWS - 1);
  localparam logic [C_W-1:0]    C_LAST   = C_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] BASE_OFF = ADDR_W'(COLS + 1);

  state_e             state_q, state_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [C_W-1:0]     c_q, c_d;
  logic [ADDR_W-1:0]  pix_q, pix_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [PIX_W-1:0]   res_q, res_d;
  logic               cap_vld_q, cap_vld_d;
  logic [3:0]         cap_k_q, cap_k_d;

  logic               k_clr, k_step, last_k, adv;
  logic [3:0]         k;
  logic [ADDR_W-1:0]  gen_addr;

  prewitt_win_addr_gen #(
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (k_clr),
    .step   (k_step),
    .base   (pix_q - BASE_OFF),
    .addr   (gen_addr),
    .k      (k),
    .last_k (last_k)
  );

  assign rd_addr = rd_en ? gen_addr : '0;
  assign wr_addr = pix_q;
  assign win     = win_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    pix_d     = pix_q;
    win_d     = win_q;
    res_d     = res_q;
    cap_vld_d = 1'b0;
    cap_k_d   = cap_k_q;
    k_clr     = 1'b0;
    k_step    = 1'b0;
    adv       = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    win_valid = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;

    // RAM data lags its read strobe by one cycle; the delayed tap index steers it into the bank.
    if (cap_vld_q) begin
      win_d[PIX_W*cap_k_q +: PIX_W] = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          r_d     = '0;
          c_d     = '0;
          pix_d   = '0;
        end
      end
      ST_SCAN: begin
        k_clr = 1'b1;
        if (r_q == '0 || r_q == R_LAST || c_q == '0 || c_q == C_LAST) begin
          state_d = ST_BORDER;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_BORDER: begin
        wr_en = 1'b1;
        adv   = 1'b1;
      end
      ST_FETCH: begin
        rd_en     = 1'b1;
        k_step    = 1'b1;
        cap_vld_d = 1'b1;
        cap_k_d   = k;
        if (last_k) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_d = ST_HAND;
      end
      ST_HAND: begin
        win_valid = 1'b1;
        if (win_ready) begin
          state_d = ST_WAITR;
        end
      end
      ST_WAITR: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        wr_data = res_q;
        adv     = 1'b1;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (adv) begin
      if (r_q == R_LAST && c_q == C_LAST) begin
        state_d = ST_FIN;
        r_d     = '0;
        c_d     = '0;
        pix_d   = '0;
      end else begin
        state_d = ST_SCAN;
        pix_d   = pix_q + 1'b1;
        if (c_q == C_LAST) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      pix_q     <= '0;
      win_q     <= '0;
      res_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      pix_q     <= pix_d;
      win_q     <= win_d;
      res_q     <= res_d;
      cap_vld_q <= cap_vld_d;
      cap_k_q   <= cap_k_d;
    end
  end

endmodule
